// File: rtl/dglitch_sd_pkg.sv
// ----------------------------------------------------------------------------
// dglitch_sd_pkg
//
// Shared definitions for the stepdown core-state deglitch stage:
//   - dgl_state_e : qualification FSM state encoding (3 bits)
//   - DGL_*_DEF   : default values for the qualification parameters
// ----------------------------------------------------------------------------
package dglitch_sd_pkg;

    typedef enum logic [2:0] {
        LOW_STABLE  = 3'd0,
        RISE_QUAL   = 3'd1,
        HIGH_STABLE = 3'd2,
        FALL_QUAL   = 3'd3,
        BLANK       = 3'd4
    } dgl_state_e;

    localparam int DGL_RISE_CNT_DEF  = 4;
    localparam int DGL_FALL_CNT_DEF  = 6;
    localparam int DGL_CNT_W_DEF     = 4;
    localparam int DGL_BLANK_CNT_DEF = 3;

endpackage : dglitch_sd_pkg

// File: rtl/dglitch_sd_corestate_sync2_celclk.sv
// ----------------------------------------------------------------------------
// sync2_celclk
//
// Two-flop synchronizer (d -> s1 -> s2) for asynchronous core-state levels
// in the CELCLK domain. Both flops clear on a synchronous active-low reset.
//
// Ports:
//   clk   : input  block clock (CELCLK)
//   rst_n : input  synchronous active-low reset
//   d     : input  raw asynchronous level
//   q     : output synchronized level (second flop)
// ----------------------------------------------------------------------------
module sync2_celclk (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s1_d;
    logic s2_q;
    logic s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule : sync2_celclk

// File: rtl/dglitch_sd_corestate.sv
// ----------------------------------------------------------------------------
// dglitch_sd_corestate
//
// Deglitch / qualification stage in front of the stepdown core-state buffer.
// The raw comparator level is synchronized, then every candidate edge must
// persist for RISE_CNT (rising) or FALL_CNT (falling) consecutive
// synchronized cycles before the registered output o follows it.
// Latency from a stable input to o is constant: 1 + RISE_CNT / 1 + FALL_CNT
// edges after the first edge that samples the new level.
//
// Optional feature (macro DGL_BLANK_EN):
//   After each qualified toggle the FSM sits in BLANK for BLANK_CNT cycles,
//   ignoring the synchronized input, then returns to the stable state that
//   matches o. Without the macro BLANK_CNT is range-checked but unused.
//
// Ports:
//   CELCLK  : input  block clock
//   CELRSTN : input  synchronous active-low reset
//   CELV    : input  supply pin, netlisting only
//   CELG    : input  ground pin, netlisting only
//   SUB     : input  substrate pin, netlisting only
//   i       : input  raw asynchronous core-state level
//   o       : output qualified level (registered) to the buffer input
//   chg     : output one-cycle pulse in the first cycle o shows a new value
//   busy    : output high while a candidate edge is being qualified
// ----------------------------------------------------------------------------
module dglitch_sd_corestate
    import dglitch_sd_pkg::*;
#(
    parameter int RISE_CNT  = DGL_RISE_CNT_DEF,
    parameter int FALL_CNT  = DGL_FALL_CNT_DEF,
    parameter int CNT_W     = DGL_CNT_W_DEF,
    parameter int BLANK_CNT = DGL_BLANK_CNT_DEF
) (
    input  logic CELCLK,
    input  logic CELRSTN,
    input  logic CELV,
    input  logic CELG,
    input  logic SUB,
    input  logic i,
    output logic o,
    output logic chg,
    output logic busy
);

    // Elaboration-time range checks on the thresholds.
    if (RISE_CNT < 1 || RISE_CNT > (1 << CNT_W) - 1) begin : g_bad_rise_cnt
        $error("RISE_CNT out of range for CNT_W");
    end
    if (FALL_CNT < 1 || FALL_CNT > (1 << CNT_W) - 1) begin : g_bad_fall_cnt
        $error("FALL_CNT out of range for CNT_W");
    end
    if (BLANK_CNT < 1 || BLANK_CNT > (1 << CNT_W) - 1) begin : g_bad_blank_cnt
        $error("BLANK_CNT out of range for CNT_W");
    end

    // Terminal counter values: qualification completes when the counter
    // holds THR-1 and the input still agrees, giving THR agreeing cycles.
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CNT - 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef DGL_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);
    localparam dgl_state_e AFTER_RISE = BLANK;
    localparam dgl_state_e AFTER_FALL = BLANK;
`else
    localparam dgl_state_e AFTER_RISE = HIGH_STABLE;
    localparam dgl_state_e AFTER_FALL = LOW_STABLE;
`endif

    // Power/ground/substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    logic s2;

    sync2_celclk u_sync2 (
        .clk   (CELCLK),
        .rst_n (CELRSTN),
        .d     (i),
        .q     (s2)
    );

    dgl_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_q, o_d;
    logic             chg_q, chg_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        chg_d   = 1'b0;

        case (state_q)
            LOW_STABLE: begin
                if (s2) begin
                    if (RISE_CNT == 1) begin
                        // Single-cycle threshold: no qualification phase.
                        state_d = AFTER_RISE;
                        cnt_d   = '0;
                        o_d     = 1'b1;
                        chg_d   = 1'b1;
                    end else begin
                        state_d = RISE_QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            RISE_QUAL: begin
                if (!s2) begin
                    // Glitch: drop the candidate, output untouched.
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == RISE_LAST) begin
                    state_d = AFTER_RISE;
                    cnt_d   = '0;
                    o_d     = 1'b1;
                    chg_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HIGH_STABLE: begin
                if (!s2) begin
                    if (FALL_CNT == 1) begin
                        state_d = AFTER_FALL;
                        cnt_d   = '0;
                        o_d     = 1'b0;
                        chg_d   = 1'b1;
                    end else begin
                        state_d = FALL_QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            FALL_QUAL: begin
                if (s2) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == FALL_LAST) begin
                    state_d = AFTER_FALL;
                    cnt_d   = '0;
                    o_d     = 1'b0;
                    chg_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef DGL_BLANK_EN
            BLANK: begin
                // s2 is ignored here; a disagreeing level is picked up by
                // the stable state on the following cycle.
                if (cnt_q == BLANK_LAST) begin
                    state_d = o_q ? HIGH_STABLE : LOW_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase

        // busy is registered alongside the state it describes.
        busy_d = (state_d == RISE_QUAL) || (state_d == FALL_QUAL);
    end

    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
        end
    end

    assign o    = o_q;
    assign chg  = chg_q;
    assign busy = busy_q;

endmodule : dglitch_sd_corestate
